// File: rtl/naozhong_pkg.sv
// naozhong_pkg: shared state encodings, BCD field limits and edit-field select codes
// for the alarm-time setting block.
package naozhong_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2
   } state_e;

   localparam logic [7:0] HOUR_MAX = 8'h23;
   localparam logic [7:0] MIN_MAX  = 8'h59;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_HOUR = 2'b10;
   localparam logic [1:0] SEL_MIN  = 2'b01;

endpackage

// File: rtl/bcd_updown_wrap.sv
// bcd_updown_wrap: combinational +1/-1 on a two-digit BCD value wrapping between 00 and max.
// Simultaneous up and dn cancel, leaving the value unchanged.
module bcd_updown_wrap (
   input  logic [7:0] in,
   input  logic [7:0] max,
   input  logic       up,
   input  logic       dn,
   output logic [7:0] out
);

   always_comb begin
      out = in;
      if (up && !dn)
         out = (in == max)          ? 8'h00 :
               (in[3:0] == 4'd9)    ? {in[7:4] + 4'd1, 4'd0} :
                                      {in[7:4], in[3:0] + 4'd1};
      else if (dn && !up)
         out = (in == 8'h00)        ? max :
               (in[3:0] == 4'd0)    ? {in[7:4] - 4'd1, 4'd9} :
                                      {in[7:4], in[3:0] - 4'd1};
   end

endmodule

// File: rtl/naozhong_set.sv
// naozhong_set: alarm-time setter; keys edit shadow BCD hour/minute, committed on the final mode press.
// Define AUTO_REPEAT_EN to add held-key auto-repeat (REPEAT_DLY / REPEAT_PER).
module naozhong_set
   import naozhong_pkg::*;
#(
   parameter logic [7:0]  HOUR_INIT   = 8'h07,
   parameter logic [7:0]  MIN_INIT    = 8'h00,
   parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000
`ifdef AUTO_REPEAT_EN
   ,
   parameter logic [31:0] REPEAT_DLY  = 32'd25_000_000,
   parameter logic [31:0] REPEAT_PER  = 32'd5_000_000
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_mode,
   input  logic       key_inc,
   input  logic       key_dec,
   output logic [7:0] shi_nao,
   output logic [7:0] fen_nao,
   output logic       set_active,
   output logic [1:0] sel_field,
   output logic [7:0] edit_shi,
   output logic [7:0] edit_fen
);

   state_e      state_q, state_d;
   logic        mode_prev_q, inc_prev_q, dec_prev_q;
   logic        ev_mode, ev_inc, ev_dec;
   logic        rep_up, rep_dn, step_up, step_dn, any_ev;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  shi_nao_q, shi_nao_d, fen_nao_q, fen_nao_d;
   logic [7:0]  edit_shi_q, edit_shi_d, edit_fen_q, edit_fen_d;
   logic [7:0]  hour_nxt, min_nxt;
   logic        set_active_q, set_active_d;
   logic [1:0]  sel_field_q, sel_field_d;

   assign ev_mode = key_mode & ~mode_prev_q;
   assign ev_inc  = key_inc  & ~inc_prev_q;
   assign ev_dec  = key_dec  & ~dec_prev_q;
   assign step_up = ev_inc | rep_up;
   assign step_dn = ev_dec | rep_dn;
   assign any_ev  = ev_mode | step_up | step_dn;

`ifdef AUTO_REPEAT_EN
   logic [31:0] rep_cnt_q, rep_cnt_d;
   logic        rep_on_q, rep_on_d, rep_fire, held;

   // Delay phase counts to REPEAT_DLY from the press edge, then period phase re-fires every REPEAT_PER.
   always_comb begin
      held      = (key_inc ^ key_dec) && (state_q != ST_IDLE);
      rep_fire  = held && (rep_on_q ? (rep_cnt_q == REPEAT_PER) : (rep_cnt_q == REPEAT_DLY));
      rep_cnt_d = !held ? 32'd0 : (ev_inc | ev_dec | rep_fire) ? 32'd1 : rep_cnt_q + 32'd1;
      rep_on_d  = held && !(ev_inc | ev_dec) && (rep_on_q || rep_fire);
      rep_up    = rep_fire & key_inc;
      rep_dn    = rep_fire & key_dec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt_q <= 32'd0;
         rep_on_q  <= 1'b0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         rep_on_q  <= rep_on_d;
      end
   end
`else
   assign rep_up = 1'b0;
   assign rep_dn = 1'b0;
`endif

   bcd_updown_wrap u_hour (
      .in  (edit_shi_q),
      .max (HOUR_MAX),
      .up  (step_up),
      .dn  (step_dn),
      .out (hour_nxt)
   );

   bcd_updown_wrap u_min (
      .in  (edit_fen_q),
      .max (MIN_MAX),
      .up  (step_up),
      .dn  (step_dn),
      .out (min_nxt)
   );

   always_comb begin
      state_d    = state_q;
      shi_nao_d  = shi_nao_q;
      fen_nao_d  = fen_nao_q;
      edit_shi_d = edit_shi_q;
      edit_fen_d = edit_fen_q;
      cnt_d      = 32'd0;
      case (state_q)
         ST_IDLE:
            if (ev_mode) begin
               state_d    = ST_SET_HOUR;
               edit_shi_d = shi_nao_q;
               edit_fen_d = fen_nao_q;
            end
         ST_SET_HOUR:
            if (ev_mode) state_d = ST_SET_MIN;
            else         edit_shi_d = hour_nxt;
         ST_SET_MIN:
            if (ev_mode) begin
               state_d   = ST_IDLE;
               shi_nao_d = edit_shi_q;
               fen_nao_d = edit_fen_q;
            end else begin
               edit_fen_d = min_nxt;
            end
         default:
            state_d = ST_IDLE;
      endcase
      // Abandon an idle edit session without committing; the shadows reload on the next entry.
      if (state_q != ST_IDLE && !any_ev) begin
         if (cnt_q == TIMEOUT_CYC - 32'd1) state_d = ST_IDLE;
         else                              cnt_d   = cnt_q + 32'd1;
      end
      set_active_d = (state_d != ST_IDLE);
      sel_field_d  = (state_d == ST_SET_HOUR) ? SEL_HOUR :
                     (state_d == ST_SET_MIN)  ? SEL_MIN  : SEL_NONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         mode_prev_q  <= 1'b0;
         inc_prev_q   <= 1'b0;
         dec_prev_q   <= 1'b0;
         cnt_q        <= 32'd0;
         shi_nao_q    <= HOUR_INIT;
         fen_nao_q    <= MIN_INIT;
         edit_shi_q   <= HOUR_INIT;
         edit_fen_q   <= MIN_INIT;
         set_active_q <= 1'b0;
         sel_field_q  <= SEL_NONE;
      end else begin
         state_q      <= state_d;
         mode_prev_q  <= key_mode;
         inc_prev_q   <= key_inc;
         dec_prev_q   <= key_dec;
         cnt_q        <= cnt_d;
         shi_nao_q    <= shi_nao_d;
         fen_nao_q    <= fen_nao_d;
         edit_shi_q   <= edit_shi_d;
         edit_fen_q   <= edit_fen_d;
         set_active_q <= set_active_d;
         sel_field_q  <= sel_field_d;
      end
   end

   assign shi_nao    = shi_nao_q;
   assign fen_nao    = fen_nao_q;
   assign edit_shi   = edit_shi_q;
   assign edit_fen   = edit_fen_q;
   assign set_active = set_active_q;
   assign sel_field  = sel_field_q;

endmodule
